// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: serializes configuration words onto a ccff chain, then optionally
// recirculates the chain once and compares CRCs of written and read-back bits.
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 64,
    parameter int WORD_W    = 8,
    parameter int CNT_W     = 13
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              start,
    input  logic              verify_en,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              shift_en,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              verify_fail
);
    localparam int BW = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] LEN = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] LEN_M1 = CNT_W'(CHAIN_LEN - 1);
    localparam logic [BW-1:0] FULL_W = BW'(WORD_W);
    typedef enum logic [1:0] {IDLE, LOAD, VERIFY, DONE} state_t;
    state_t state, state_nx;
    logic [WORD_W-1:0] word_q;
    logic [BW-1:0] bits_q;
    logic [CNT_W-1:0] cnt, cnt_inc;
    logic [15:0] crc_wr, crc_rd, crc_rd_nx;
    logic ver_q, chain_full, load_shift, last_verify;
    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
    endfunction
    always_comb begin
        chain_full  = cnt == LEN;
        load_shift  = state == LOAD && bits_q != '0 && !chain_full;
        last_verify = state == VERIFY && cnt == LEN_M1;
        cnt_inc     = cnt + CNT_W'(1);
        shift_en    = load_shift || state == VERIFY;
        ccff_head   = state == VERIFY ? ccff_tail : load_shift && word_q[WORD_W-1];
        // never accept a word whose bits would all fall past the end of the chain
        cfg_ready   = state == LOAD && (bits_q == '0 || (bits_q == BW'(1) && load_shift))
                      && (load_shift ? cnt_inc : cnt) != LEN;
        busy        = state != IDLE;
        done        = state == DONE;
        crc_rd_nx   = crc_step(crc_rd, ccff_tail);
        state_nx    = state;
        case (state)
            IDLE:    if (start) state_nx = LOAD;
            LOAD:    if (chain_full) state_nx = ver_q ? VERIFY : DONE;
            VERIFY:  if (last_verify) state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            state       <= IDLE;
            word_q      <= '0;
            bits_q      <= '0;
            cnt         <= '0;
            crc_wr      <= 16'hFFFF;
            crc_rd      <= 16'hFFFF;
            ver_q       <= 1'b0;
            verify_fail <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start) begin
                ver_q       <= verify_en;
                verify_fail <= 1'b0;
                crc_wr      <= 16'hFFFF;
                crc_rd      <= 16'hFFFF;
                cnt         <= '0;
                bits_q      <= '0;
            end
            if (state == LOAD) begin
                // chain full: leftover low bits of a partial final word are dropped
                if (chain_full) begin
                    cnt    <= '0;
                    bits_q <= '0;
                end
                if (load_shift) begin
                    word_q <= word_q << 1;
                    bits_q <= bits_q - BW'(1);
                    cnt    <= cnt_inc;
                    crc_wr <= crc_step(crc_wr, word_q[WORD_W-1]);
                end
                if (cfg_valid && cfg_ready) begin
                    word_q <= cfg_data;
                    bits_q <= FULL_W;
                end
            end
            if (state == VERIFY) begin
                crc_rd <= crc_rd_nx;
                cnt    <= last_verify ? '0 : cnt_inc;
                if (last_verify) verify_fail <= crc_rd_nx != crc_wr;
            end
        end
    end
endmodule
